bfs_level_sequencer: RTL and testbench
======================================

Name: bfs_level_sequencer

Overview:
- Sequences one BFS run level by level.
- Each level has two phases:
  - The dense-to-sparse frontier extractor, launched with lookFor = current level.
  - The frontier expansion engine, which consumes the sparse frontier.
- Sparse frontier buffers A and B alternate between levels (ping-pong).
- Sits between the host register file and the two engines, and owns their start/finished handshakes and pointer configuration.

Parameters:
DATA_W, 32, width of pointers, counts and levels
TIMEOUT_W, 24, width of per-phase watchdog counter
TIMEOUT_CYCLES, 0, phase watchdog limit in cycles; 0 disables watchdog

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
io_start  in  1  run request, level-held by host
io_finished  out  1  run complete; held until io_start low
io_denseBasePtr  in  DATA_W  distance vector base byte address
io_denseCount  in  DATA_W  distance vector element count
io_sparseBasePtrA  in  DATA_W  frontier buffer A base
io_sparseBasePtrB  in  DATA_W  frontier buffer B base
io_rootLevel  in  DATA_W  first level to extract
io_maxLevels  in  DATA_W  max levels to process
io_levelsDone  out  DATA_W  completed extraction phases
io_totalVisited  out  DATA_W  sum of frontier sizes, wraps mod 2^DATA_W
io_status  out  2  0 running/none, 1 frontier empty, 2 level limit, 3 timeout
d2s_start  out  1  extractor start
d2s_finished  in  1  extractor finished
d2s_denseBasePtr  out  DATA_W  = latched io_denseBasePtr
d2s_sparseBasePtr  out  DATA_W  current write buffer
d2s_denseCount  out  DATA_W  = latched io_denseCount
d2s_lookFor  out  DATA_W  current level
d2s_sparseCount  in  DATA_W  extracted frontier size, valid while d2s_finished
exp_start  out  1  expansion start
exp_finished  in  1  expansion finished
exp_frontierPtr  out  DATA_W  buffer just written by extractor
exp_frontierSize  out  DATA_W  latched frontier size
exp_nextLevel  out  DATA_W  current level + 1

Behaviour:
- Reset (async, any time including mid-run):
  - State goes to IDLE.
  - All outputs and registers go to 0; buffer select goes to A.
  - Engines see start drop immediately.
- Handshake, both engines:
  - Start is held high until finished is seen high.
  - Start is then dropped, and the sequencer waits for finished low before continuing.
  - Finished is sampled only in the RUN states; a stray finished elsewhere is ignored.
- States:
  - IDLE:
    - On io_start: latch all io_* config.
    - Set level = io_rootLevel; clear levelsDone, totalVisited and status; set buffer select = A.
    - If io_maxLevels == 0: go to DONE with status 2.
    - Otherwise go to D2S_RUN.
  - D2S_RUN:
    - d2s_start = 1.
    - On d2s_finished: capture sparseCount into frontierSize; levelsDone += 1; totalVisited += sparseCount; go to D2S_REL.
  - D2S_REL:
    - d2s_start = 0.
    - When d2s_finished = 0:
      - frontierSize == 0: go to DONE, status 1.
      - else levelsDone == maxLevels: go to DONE, status 2.
      - else go to EXP_RUN.
  - EXP_RUN:
    - exp_start = 1.
    - exp_frontierPtr = current buffer.
    - On exp_finished: go to EXP_REL.
  - EXP_REL:
    - exp_start = 0.
    - When exp_finished = 0: level += 1, toggle buffer select, go to D2S_RUN.
  - DONE:
    - io_finished = 1.
    - Outputs stay frozen.
    - When io_start = 0: go to IDLE. Status and counters keep their values until the next start.
- Buffer select: d2s_sparseBasePtr = A when select = 0, else B. exp_frontierPtr equals that same value during the EXP states.
- Level arithmetic: level and exp_nextLevel wrap mod 2^DATA_W, with no saturation.
- Watchdog (only when TIMEOUT_CYCLES != 0):
  - Counter clears on entry to each RUN/REL state and increments every cycle in that state.
  - When it reaches TIMEOUT_CYCLES: drop both starts, go to DONE with status 3.
  - If finished arrives in the same cycle as expiry, the normal transition wins.
- io_start changes outside IDLE/DONE are ignored.
- Latency:
  - IDLE to d2s_start high: 1 cycle after io_start is sampled.
  - Each REL state to the next start: 1 cycle after finished drops.

Test Plan:
- 1. Root 1, maxLevels 8; the extractor model returns sparseCount 5, 3, 0 → three extractions, two expansions, lookFor 1,2,3, sparse pointers A,B,A, status 1, levelsDone 3, totalVisited 8, io_finished high until io_start drops.
- 2. maxLevels 2, sparseCount always 4 → two extractions, one expansion, status 2, levelsDone 2, totalVisited 8, exp_nextLevel 2 during the expansion (root 1).
- 3. maxLevels 0 → no engine start ever; io_finished one cycle after start; status 2.
- 4. TIMEOUT_CYCLES 16, expansion never finishes → exp_start drops after 16 cycles in EXP_RUN; status 3; extractor not restarted.
- 5. Reset asserted in EXP_RUN → all outputs 0 on the same edge; a new start runs from io_rootLevel using buffer A.
- 6. Extractor holds d2s_finished 5 cycles after start drops → sequencer stays in D2S_REL, with no exp_start until d2s_finished is low.

Source files
------------

// File: rtl/bfs_level_sequencer_if.sv
// Host/engine signal bundle for the BFS level sequencer.
// The sequencer is the master: it owns both engine start handshakes and the host status.
interface bfs_level_sequencer_if #(parameter int DATA_W = 32);
  logic              io_start;
  logic              io_finished;
  logic [DATA_W-1:0] io_denseBasePtr;
  logic [DATA_W-1:0] io_denseCount;
  logic [DATA_W-1:0] io_sparseBasePtrA;
  logic [DATA_W-1:0] io_sparseBasePtrB;
  logic [DATA_W-1:0] io_rootLevel;
  logic [DATA_W-1:0] io_maxLevels;
  logic [DATA_W-1:0] io_levelsDone;
  logic [DATA_W-1:0] io_totalVisited;
  logic [1:0]        io_status;
  logic              d2s_start;
  logic              d2s_finished;
  logic [DATA_W-1:0] d2s_denseBasePtr;
  logic [DATA_W-1:0] d2s_sparseBasePtr;
  logic [DATA_W-1:0] d2s_denseCount;
  logic [DATA_W-1:0] d2s_lookFor;
  logic [DATA_W-1:0] d2s_sparseCount;
  logic              exp_start;
  logic              exp_finished;
  logic [DATA_W-1:0] exp_frontierPtr;
  logic [DATA_W-1:0] exp_frontierSize;
  logic [DATA_W-1:0] exp_nextLevel;

  modport master (
    input  io_start, io_denseBasePtr, io_denseCount, io_sparseBasePtrA, io_sparseBasePtrB,
           io_rootLevel, io_maxLevels, d2s_finished, d2s_sparseCount, exp_finished,
    output io_finished, io_levelsDone, io_totalVisited, io_status,
           d2s_start, d2s_denseBasePtr, d2s_sparseBasePtr, d2s_denseCount, d2s_lookFor,
           exp_start, exp_frontierPtr, exp_frontierSize, exp_nextLevel
  );

  modport slave (
    output io_start, io_denseBasePtr, io_denseCount, io_sparseBasePtrA, io_sparseBasePtrB,
           io_rootLevel, io_maxLevels, d2s_finished, d2s_sparseCount, exp_finished,
    input  io_finished, io_levelsDone, io_totalVisited, io_status,
           d2s_start, d2s_denseBasePtr, d2s_sparseBasePtr, d2s_denseCount, d2s_lookFor,
           exp_start, exp_frontierPtr, exp_frontierSize, exp_nextLevel
  );
endinterface

// File: rtl/bfs_level_sequencer.sv
// Level-by-level BFS sequencer: extract frontier, expand it, swap ping-pong buffers, repeat
// until the frontier is empty, the level budget is spent or a phase watchdog fires.
module bfs_level_sequencer #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_W      = 24,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  bfs_level_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, D2S_RUN, D2S_REL, EXP_RUN, EXP_REL, DONE} state_t;

  localparam bit                   WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t              state, state_nxt;
  logic [1:0]          status, status_nxt;
  logic [DATA_W-1:0]   dense_base, dense_count, base_a, base_b, max_levels;
  logic [DATA_W-1:0]   level, next_level, frontier_size, levels_done, total_visited;
  logic                sel;
  logic [TIMEOUT_W-1:0] wdog;
  logic                wd_exp;

  assign wd_exp = WD_EN && (wdog == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      status <= 2'd0;
    end else begin
      state <= state_nxt;
      status <= status_nxt;
    end
  end

  // A finished arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_nxt  = state;
    status_nxt = status;
    case (state)
      IDLE: if (bus.io_start) begin
        if (bus.io_maxLevels == '0) begin
          state_nxt  = DONE;
          status_nxt = 2'd2;
        end else begin
          state_nxt  = D2S_RUN;
          status_nxt = 2'd0;
        end
      end
      D2S_RUN: begin
        if (bus.d2s_finished) state_nxt = D2S_REL;
        else if (wd_exp) begin state_nxt = DONE; status_nxt = 2'd3; end
      end
      D2S_REL: begin
        if (!bus.d2s_finished) begin
          if (frontier_size == '0) begin
            state_nxt  = DONE;
            status_nxt = 2'd1;
          end else if (levels_done == max_levels) begin
            state_nxt  = DONE;
            status_nxt = 2'd2;
          end else begin
            state_nxt = EXP_RUN;
          end
        end else if (wd_exp) begin state_nxt = DONE; status_nxt = 2'd3; end
      end
      EXP_RUN: begin
        if (bus.exp_finished) state_nxt = EXP_REL;
        else if (wd_exp) begin state_nxt = DONE; status_nxt = 2'd3; end
      end
      EXP_REL: begin
        if (!bus.exp_finished) state_nxt = D2S_RUN;
        else if (wd_exp) begin state_nxt = DONE; status_nxt = 2'd3; end
      end
      DONE:    if (!bus.io_start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dense_base    <= '0;
      dense_count   <= '0;
      base_a        <= '0;
      base_b        <= '0;
      max_levels    <= '0;
      level         <= '0;
      next_level    <= '0;
      frontier_size <= '0;
      levels_done   <= '0;
      total_visited <= '0;
      sel           <= 1'b0;
      wdog          <= '0;
    end else begin
      case (state)
        IDLE: if (bus.io_start) begin
          dense_base    <= bus.io_denseBasePtr;
          dense_count   <= bus.io_denseCount;
          base_a        <= bus.io_sparseBasePtrA;
          base_b        <= bus.io_sparseBasePtrB;
          max_levels    <= bus.io_maxLevels;
          level         <= bus.io_rootLevel;
          next_level    <= bus.io_rootLevel + 1'b1;
          frontier_size <= '0;
          levels_done   <= '0;
          total_visited <= '0;
          sel           <= 1'b0;
        end
        D2S_RUN: if (bus.d2s_finished) begin
          frontier_size <= bus.d2s_sparseCount;
          levels_done   <= levels_done + 1'b1;
          total_visited <= total_visited + bus.d2s_sparseCount;
        end
        EXP_REL: if (!bus.exp_finished) begin
          level      <= level + 1'b1;
          next_level <= next_level + 1'b1;
          sel        <= ~sel;
        end
        default: ;
      endcase
      // Watchdog restarts on every state change and only runs inside phase states.
      if (state_nxt != state) wdog <= '0;
      else if (state inside {D2S_RUN, D2S_REL, EXP_RUN, EXP_REL}) wdog <= wdog + 1'b1;
    end
  end

  assign bus.io_finished       = (state == DONE);
  assign bus.io_status         = status;
  assign bus.io_levelsDone     = levels_done;
  assign bus.io_totalVisited   = total_visited;
  assign bus.d2s_start         = (state == D2S_RUN);
  assign bus.d2s_denseBasePtr  = dense_base;
  assign bus.d2s_denseCount    = dense_count;
  assign bus.d2s_sparseBasePtr = sel ? base_b : base_a;
  assign bus.d2s_lookFor       = level;
  assign bus.exp_start         = (state == EXP_RUN);
  assign bus.exp_frontierPtr   = sel ? base_b : base_a;
  assign bus.exp_frontierSize  = frontier_size;
  assign bus.exp_nextLevel     = next_level;
endmodule

// File: tb/tb_bfs_level_sequencer.sv
// Bench for bfs_level_sequencer: behavioural engine models pop expected launch records from
// scoreboard queues filled when each run is configured.
module tb_bfs_level_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bfs_level_sequencer_if #(.DATA_W(32)) bus();

  bfs_level_sequencer #(.DATA_W(32), .TIMEOUT_W(24), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  localparam logic [31:0] BASE_A = 32'h0000_1000;
  localparam logic [31:0] BASE_B = 32'h0000_2000;
  localparam logic [31:0] DBASE  = 32'h0000_8000;
  localparam logic [31:0] DCNT   = 32'd64;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {logic [31:0] look; logic [31:0] ptr;} d2s_rec_t;
  typedef struct {logic [31:0] ptr; logic [31:0] size; logic [31:0] nxt;} exp_rec_t;

  d2s_rec_t    d2s_q[$];
  exp_rec_t    exp_q[$];
  logic [31:0] resp_q[$];
  int d2s_hold = 0;
  bit exp_hang = 1'b0;
  int exp_hi   = 0;

  // Extractor model: finish 2 cycles after launch, hold finished d2s_hold cycles after start drops.
  d2s_rec_t dr;
  bit d2s_seen;
  int d2s_cnt, d2s_rel;
  always @(negedge clk) begin
    if (reset) begin
      bus.d2s_finished = 1'b0; bus.d2s_sparseCount = '0;
      d2s_seen = 1'b0; d2s_cnt = 0; d2s_rel = 0;
    end else if (bus.d2s_start) begin
      if (!d2s_seen) begin
        d2s_seen = 1'b1; d2s_cnt = 0; d2s_rel = 0;
        if (d2s_q.size() == 0) chk("d2s_unexpected_start", d2s_q.size(), 1);
        else begin
          dr = d2s_q.pop_front();
          chk("d2s_lookFor", bus.d2s_lookFor, dr.look);
          chk("d2s_sparsePtr", bus.d2s_sparseBasePtr, dr.ptr);
        end
        chk("d2s_denseBase", bus.d2s_denseBasePtr, DBASE);
        chk("d2s_denseCount", bus.d2s_denseCount, DCNT);
      end else d2s_cnt++;
      if (d2s_cnt == 2 && !bus.d2s_finished) begin
        bus.d2s_finished = 1'b1;
        bus.d2s_sparseCount = (resp_q.size() != 0) ? resp_q.pop_front() : 32'd0;
      end
    end else if (bus.d2s_finished) begin
      chk("rel_no_exp_start", bus.exp_start, 0);
      if (d2s_rel >= d2s_hold) begin bus.d2s_finished = 1'b0; d2s_seen = 1'b0; end
      else d2s_rel++;
    end else d2s_seen = 1'b0;
  end

  // Expansion model: finish on the second cycle of start unless told to hang.
  exp_rec_t er;
  bit exp_seen;
  int exp_cnt;
  always @(negedge clk) begin
    if (reset) begin
      bus.exp_finished = 1'b0; exp_seen = 1'b0; exp_cnt = 0;
    end else if (bus.exp_start) begin
      exp_hi++;
      if (!exp_seen) begin
        exp_seen = 1'b1; exp_cnt = 0;
        if (exp_q.size() == 0) chk("exp_unexpected_start", exp_q.size(), 1);
        else begin
          er = exp_q.pop_front();
          chk("exp_frontierPtr", bus.exp_frontierPtr, er.ptr);
          chk("exp_frontierSize", bus.exp_frontierSize, er.size);
          chk("exp_nextLevel", bus.exp_nextLevel, er.nxt);
        end
      end else exp_cnt++;
      if (exp_cnt == 1 && !exp_hang) bus.exp_finished = 1'b1;
    end else begin
      bus.exp_finished = 1'b0; exp_seen = 1'b0;
    end
  end

  task automatic cfg(input logic [31:0] root, input logic [31:0] maxl);
    bus.io_denseBasePtr = DBASE;  bus.io_denseCount = DCNT;
    bus.io_sparseBasePtrA = BASE_A; bus.io_sparseBasePtrB = BASE_B;
    bus.io_rootLevel = root; bus.io_maxLevels = maxl;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_io_finished"}, bus.io_finished, 0);
    chk({pfx, "_io_status"}, bus.io_status, 0);
    chk({pfx, "_io_levelsDone"}, bus.io_levelsDone, 0);
    chk({pfx, "_io_totalVisited"}, bus.io_totalVisited, 0);
    chk({pfx, "_d2s_start"}, bus.d2s_start, 0);
    chk({pfx, "_d2s_denseBase"}, bus.d2s_denseBasePtr, 0);
    chk({pfx, "_d2s_sparsePtr"}, bus.d2s_sparseBasePtr, 0);
    chk({pfx, "_d2s_denseCount"}, bus.d2s_denseCount, 0);
    chk({pfx, "_d2s_lookFor"}, bus.d2s_lookFor, 0);
    chk({pfx, "_exp_start"}, bus.exp_start, 0);
    chk({pfx, "_exp_frontierPtr"}, bus.exp_frontierPtr, 0);
    chk({pfx, "_exp_frontierSize"}, bus.exp_frontierSize, 0);
    chk({pfx, "_exp_nextLevel"}, bus.exp_nextLevel, 0);
  endtask

  task automatic finish_run(input logic [1:0] st, input logic [31:0] lv, input logic [31:0] tot);
    for (int i = 0; i < 400 && bus.io_finished !== 1'b1; i++) @(negedge clk);
    chk("run_finished", bus.io_finished, 1);
    chk("io_status", bus.io_status, st);
    chk("io_levelsDone", bus.io_levelsDone, lv);
    chk("io_totalVisited", bus.io_totalVisited, tot);
    chk("d2s_q_left", d2s_q.size(), 0);
    chk("exp_q_left", exp_q.size(), 0);
    chk("resp_q_left", resp_q.size(), 0);
    repeat (2) @(negedge clk);
    chk("finished_held", bus.io_finished, 1);
    bus.io_start = 1'b0;
    @(negedge clk);
    chk("finished_drop", bus.io_finished, 0);
    chk("status_kept", bus.io_status, st);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.io_start = 1'b0;
    cfg(32'd0, 32'd0);
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;
    @(negedge clk);

    // Frontier shrinks to empty after three extractions.
    cfg(32'd1, 32'd8);
    d2s_q.push_back('{32'd1, BASE_A}); d2s_q.push_back('{32'd2, BASE_B}); d2s_q.push_back('{32'd3, BASE_A});
    exp_q.push_back('{BASE_A, 32'd5, 32'd2}); exp_q.push_back('{BASE_B, 32'd3, 32'd3});
    resp_q.push_back(32'd5); resp_q.push_back(32'd3); resp_q.push_back(32'd0);
    bus.io_start = 1'b1;
    finish_run(2'd1, 32'd3, 32'd8);

    // Level budget of 2.
    cfg(32'd1, 32'd2);
    d2s_q.push_back('{32'd1, BASE_A}); d2s_q.push_back('{32'd2, BASE_B});
    exp_q.push_back('{BASE_A, 32'd4, 32'd2});
    resp_q.push_back(32'd4); resp_q.push_back(32'd4);
    bus.io_start = 1'b1;
    finish_run(2'd2, 32'd2, 32'd8);

    // Zero level budget: straight to DONE.
    cfg(32'd7, 32'd0);
    bus.io_start = 1'b1;
    @(negedge clk);
    chk("max0_finished_1cyc", bus.io_finished, 1);
    chk("max0_no_d2s_start", bus.d2s_start, 0);
    finish_run(2'd2, 32'd0, 32'd0);

    // Expansion hangs: watchdog fires after 16 cycles.
    cfg(32'd5, 32'd4);
    d2s_q.push_back('{32'd5, BASE_A});
    exp_q.push_back('{BASE_A, 32'd7, 32'd6});
    resp_q.push_back(32'd7);
    exp_hang = 1'b1; exp_hi = 0;
    bus.io_start = 1'b1;
    finish_run(2'd3, 32'd1, 32'd7);
    chk("wd_exp_start_cycles", exp_hi, 16);
    exp_hang = 1'b0;

    // Reset while expanding, then a fresh run.
    cfg(32'd3, 32'd8);
    d2s_q.push_back('{32'd3, BASE_A});
    exp_q.push_back('{BASE_A, 32'd2, 32'd4});
    resp_q.push_back(32'd2);
    exp_hang = 1'b1;
    bus.io_start = 1'b1;
    for (int i = 0; i < 100 && bus.exp_start !== 1'b1; i++) @(negedge clk);
    chk("mid_exp_running", bus.exp_start, 1);
    #2 reset = 1'b1;
    #1 check_zero("rst_mid");
    bus.io_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_hang = 1'b0;
    d2s_q.delete(); exp_q.delete(); resp_q.delete();
    @(negedge clk);
    cfg(32'd9, 32'd1);
    d2s_q.push_back('{32'd9, BASE_A});
    resp_q.push_back(32'd6);
    bus.io_start = 1'b1;
    finish_run(2'd2, 32'd1, 32'd6);

    // Extractor keeps finished high 5 cycles after start drops.
    cfg(32'd0, 32'd3);
    d2s_q.push_back('{32'd0, BASE_A}); d2s_q.push_back('{32'd1, BASE_B});
    exp_q.push_back('{BASE_A, 32'd2, 32'd1});
    resp_q.push_back(32'd2); resp_q.push_back(32'd0);
    d2s_hold = 5;
    bus.io_start = 1'b1;
    finish_run(2'd1, 32'd2, 32'd2);
    d2s_hold = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
